mux_sel_rr_arbiter: RTL and testbench

- Round-robin arbiter for the team's 32:1 single-bit select multiplexer.
- Shares the mux between 32 requesters and drives the 5-bit select `sel` for the winner.
- Holds the grant until the owner releases it, or until a hold timeout expires.
- Sits between the requesting sources and the mux select input. Index i maps to mux data input A(i+1).

---
 rtl/mux_sel_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin owner of the 32:1 mux select; a grant is held until done, request drop or hold limit.
// Define MUX_ARB_TIMEOUT_EN to enable the MAX_HOLD grant limit and the timeout pulse.
module mux_sel_rr_arbiter #(
  parameter int N_REQ    = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] ptr, ptr_next, sel_next, winner;
  logic [N_REQ-1:0] gnt_next;
  logic             gnt_valid_next, timeout_next;
  logic             any_req, limit_hit, release_now;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || N_REQ != (1 << SEL_W)) begin : g_bad_cfg
    $error("mux_sel_rr_arbiter: illegal parameter combination");
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_next;
  assign limit_hit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Scanning downward lets the nearest request at or after ptr overwrite the others.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        winner  = ptr + SEL_W'(k);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    sel_next       = sel;
    gnt_next       = gnt;
    gnt_valid_next = gnt_valid;
    ptr_next       = ptr;
    timeout_next   = 1'b0;
    release_now    = done || !req[sel] || limit_hit;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_next  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next     = GRANT;
          sel_next       = winner;
          gnt_next       = N_REQ'(1) << winner;
          gnt_valid_next = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next  = 8'd0;
`endif
        end
      end
      GRANT: begin
        // A voluntary release on the limit edge is not reported as a timeout.
        if (release_now) begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          ptr_next       = sel + SEL_W'(1);
          timeout_next   = limit_hit && !done && req[sel];
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next  = hold_cnt + 8'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      timeout   <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
`endif
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      gnt       <= gnt_next;
      gnt_valid <= gnt_valid_next;
      ptr       <= ptr_next;
      timeout   <= timeout_next;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt  <= hold_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: behavioural arbiter model compared every cycle,
// plus directed sequences with literal grant-order expectations.
`timescale 1ns/1ps
module tb_mux_sel_rr_arbiter;

  localparam int MAX_HOLD = 16;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        done = 1'b0;
  logic [31:0] req  = '0;
  logic [4:0]  sel;
  logic [31:0] gnt;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mux_sel_rr_arbiter #(.N_REQ(32), .SEL_W(5), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .sel      (sel),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  // Model: who owns the mux, how many cycles it has been visible, and where the rotation starts.
  bit m_valid = 1'b0;
  bit m_to    = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_to = 1'b0; m_sel = 0; m_ptr = 0; m_held = 0;
    end else begin
      m_to = 1'b0;
      if (!m_valid) begin
        if (req != 0) begin
          for (int k = 0; k < 32; k++) begin
            if (req[(m_ptr + k) % 32]) begin
              m_sel = (m_ptr + k) % 32;
              break;
            end
          end
          m_valid = 1'b1;
          m_held  = 1;
        end
      end else if (done || !req[m_sel]) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 32;
      end else if (LIMIT_ON && m_held == MAX_HOLD) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 32;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model sel", {27'd0, sel}, m_sel);
      check_output("model gnt", gnt, m_valid ? (32'd1 << m_sel) : 32'd0);
      check_output("model gnt_valid", {31'd0, gnt_valid}, {31'd0, m_valid});
      check_output("model timeout", {31'd0, timeout}, {31'd0, m_to});
    end
  end

  task automatic apply_stimulus(input logic r, input logic d, input logic [31:0] q);
    rst  = r;
    done = d;
    req  = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int idx, input string name);
    int n = 0;
    while (!gnt_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output({name, " valid"}, {31'd0, gnt_valid}, 32'd1);
    check_output({name, " sel"}, {27'd0, sel}, idx);
    check_output({name, " gnt"}, gnt, 32'd1 << idx);
  endtask

  initial begin
    int order[5] = '{0, 2, 31, 0, 2};
    int held;
    int to_seen;

    $display("[TB] reset with all requests high");
    apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
    chk_en = 1'b1;
    check_output("reset gnt_valid", {31'd0, gnt_valid}, 32'd0);
    check_output("reset sel", {27'd0, sel}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
    check_output("reset gnt", gnt, 32'd0);
    check_output("reset timeout", {31'd0, timeout}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'hFFFF_FFFF);
    check_output("first grant latency", {31'd0, gnt_valid}, 32'd1);
    expect_grant(0, "first grant");
    apply_stimulus(1'b0, 1'b1, 32'd0);

    $display("[TB] rotation over 0, 2, 31");
    apply_stimulus(1'b1, 1'b0, 32'd0);
    foreach (order[i]) begin
      apply_stimulus(1'b0, 1'b0, 32'h8000_0005);
      expect_grant(order[i], "rotation");
      apply_stimulus(1'b0, 1'b1, 32'h8000_0005);
      check_output("rotation gap", {31'd0, gnt_valid}, 32'd0);
    end

    $display("[TB] wrap-around from index 30");
    apply_stimulus(1'b0, 1'b0, 32'h4000_0000);
    expect_grant(30, "wrap setup");
    apply_stimulus(1'b0, 1'b0, 32'h8000_0001);
    check_output("wrap drop", {31'd0, gnt_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h8000_0001);
    expect_grant(31, "wrap first");
    apply_stimulus(1'b0, 1'b1, 32'h8000_0001);
    apply_stimulus(1'b0, 1'b0, 32'h8000_0001);
    expect_grant(0, "wrap second");
    apply_stimulus(1'b0, 1'b1, 32'h8000_0001);

    $display("[TB] owner drops its request");
    apply_stimulus(1'b0, 1'b0, 32'h0000_0080);
    expect_grant(7, "owner");
    apply_stimulus(1'b0, 1'b0, 32'h0000_0208);
    check_output("owner drop", {31'd0, gnt_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0000_0208);
    expect_grant(9, "after drop");
    apply_stimulus(1'b0, 1'b0, 32'd0);

    $display("[TB] long hold on index 5");
    apply_stimulus(1'b0, 1'b0, 32'h0000_0020);
    expect_grant(5, "hold");
    held = 1;
    to_seen = 0;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0000_0020);
      if (!gnt_valid) break;
      held++;
    end
    check_output("hold cycles", held, 32'd16);
    check_output("timeout pulse", {31'd0, timeout}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'h0000_0020);
    check_output("timeout width", {31'd0, timeout}, 32'd0);
    expect_grant(5, "regrant");
`else
    for (int i = 0; i < 110; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0000_0020);
      if (gnt_valid) held++;
      if (timeout) to_seen++;
    end
    check_output("hold cycles", held, 32'd111);
    check_output("timeout never", to_seen, 32'd0);
`endif
    apply_stimulus(1'b0, 1'b0, 32'd0);

    $display("[TB] reset during a grant");
    apply_stimulus(1'b0, 1'b0, 32'h0000_1000);
    expect_grant(12, "pre-reset");
    apply_stimulus(1'b0, 1'b0, 32'h0000_1000);
    apply_stimulus(1'b1, 1'b0, 32'h0000_1000);
    check_output("mid reset valid", {31'd0, gnt_valid}, 32'd0);
    check_output("mid reset sel", {27'd0, sel}, 32'd0);
    check_output("mid reset gnt", gnt, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0000_1002);
    expect_grant(1, "post-reset");
    apply_stimulus(1'b0, 1'b1, 32'h0000_1002);
    apply_stimulus(1'b0, 1'b0, 32'h0000_1002);
    expect_grant(12, "post-reset next");
    apply_stimulus(1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
